// File: rtl/fb_write_ctrl.sv
// Write-side sequencer for the double-buffered frame BRAM: 2x2 decimation, linear addressing, tear-free bank swap.
// Optional drop counter output o_drop_cnt is enabled by defining FB_WRITE_DROP_CNT_EN.
module fb_write_ctrl #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [10:0]       i_h_addr,
    input  logic [9:0]        i_v_addr,
    input  logic              i_valid,
    input  logic [11:0]       i_pixel_data,
    input  logic              i_frame_start,
    input  logic              i_rd_frame_done,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [11:0]       o_wr_data,
    output logic              o_wr_bank,
    output logic              o_rd_bank,
    output logic              o_swap,
    output logic              o_frame_ready
`ifdef FB_WRITE_DROP_CNT_EN
    ,
    output logic [15:0]       o_drop_cnt
`endif
);

    localparam int              N_PIX    = IMG_W * IMG_H;
    // One extra bit so a frame filling all 2^ADDR_W locations still counts correctly.
    localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W + 1)'(N_PIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_SWAP
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   pix_cnt;
    logic [9:0]        h_half;
    logic [8:0]        v_half;
    logic              accept;
    logic [ADDR_W-1:0] lin_addr;

    assign h_half = i_h_addr[10:1];
    assign v_half = i_v_addr[9:1];

    assign accept = (state == ST_WRITE) && i_valid && !i_h_addr[0] && !i_v_addr[0]
                    && (int'(h_half) < IMG_W) && (int'(v_half) < IMG_H);

    assign lin_addr = ADDR_W'(v_half) * ADDR_W'(IMG_W) + ADDR_W'(h_half);

    // The reader always owns the bank the writer does not.
    assign o_rd_bank = ~o_wr_bank;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            pix_cnt       <= '0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_wr_bank     <= 1'b0;
            o_swap        <= 1'b0;
            o_frame_ready <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            o_swap  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        state   <= ST_WRITE;
                        pix_cnt <= '0;
                    end
                end
                ST_WRITE: begin
                    if (i_frame_start) begin
                        pix_cnt <= '0;
                    end else if (accept) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= lin_addr;
                        o_wr_data <= i_pixel_data;
                        pix_cnt   <= pix_cnt + 1'b1;
                        if (pix_cnt == LAST_PIX) begin
                            state         <= ST_WAIT_SWAP;
                            o_frame_ready <= 1'b1;
                        end
                    end
                end
                ST_WAIT_SWAP: begin
                    if (i_rd_frame_done) begin
                        o_wr_bank     <= ~o_wr_bank;
                        o_swap        <= 1'b1;
                        o_frame_ready <= 1'b0;
                        if (i_frame_start) begin
                            state   <= ST_WRITE;
                            pix_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FB_WRITE_DROP_CNT_EN
    logic drop_evt;

    // A start while writing abandons the partial frame; a start while waiting loses that camera frame.
    assign drop_evt = i_frame_start &&
                      ((state == ST_WRITE) || ((state == ST_WAIT_SWAP) && !i_rd_frame_done));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_drop_cnt <= '0;
        end else if (drop_evt && (o_drop_cnt != 16'hFFFF)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Self-checking bench for fb_write_ctrl: default-geometry DUT for addressing and the full frame,
// plus a tiny-geometry DUT for the simultaneous swap+start corner.
module tb_fb_write_ctrl;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Default-geometry DUT
    logic        i_rst = 1'b0;
    logic [10:0] i_h_addr = '0;
    logic [9:0]  i_v_addr = '0;
    logic        i_valid = 1'b0;
    logic [11:0] i_pixel_data = '0;
    logic        i_frame_start = 1'b0;
    logic        i_rd_frame_done = 1'b0;
    logic        o_wr_en;
    logic [16:0] o_wr_addr;
    logic [11:0] o_wr_data;
    logic        o_wr_bank, o_rd_bank, o_swap, o_frame_ready;
`ifdef FB_WRITE_DROP_CNT_EN
    logic [15:0] o_drop_cnt;
`endif

    // Small-geometry DUT (4x2 stored frame)
    logic        s_rst = 1'b0;
    logic [10:0] s_h_addr = '0;
    logic [9:0]  s_v_addr = '0;
    logic        s_valid = 1'b0;
    logic [11:0] s_pixel_data = '0;
    logic        s_frame_start = 1'b0;
    logic        s_rd_frame_done = 1'b0;
    logic        s_wr_en;
    logic [2:0]  s_wr_addr;
    logic [11:0] s_wr_data;
    logic        s_wr_bank, s_rd_bank, s_swap, s_frame_ready;
`ifdef FB_WRITE_DROP_CNT_EN
    logic [15:0] s_drop_cnt;
`endif

    fb_write_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_h_addr(i_h_addr), .i_v_addr(i_v_addr),
        .i_valid(i_valid), .i_pixel_data(i_pixel_data), .i_frame_start(i_frame_start),
        .i_rd_frame_done(i_rd_frame_done), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_wr_bank(o_wr_bank), .o_rd_bank(o_rd_bank),
        .o_swap(o_swap), .o_frame_ready(o_frame_ready)
`ifdef FB_WRITE_DROP_CNT_EN
        , .o_drop_cnt(o_drop_cnt)
`endif
    );

    fb_write_ctrl #(.IMG_W(4), .IMG_H(2), .ADDR_W(3)) dut_s (
        .i_clk(i_clk), .i_rst(s_rst), .i_h_addr(s_h_addr), .i_v_addr(s_v_addr),
        .i_valid(s_valid), .i_pixel_data(s_pixel_data), .i_frame_start(s_frame_start),
        .i_rd_frame_done(s_rd_frame_done), .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr),
        .o_wr_data(s_wr_data), .o_wr_bank(s_wr_bank), .o_rd_bank(s_rd_bank),
        .o_swap(s_swap), .o_frame_ready(s_frame_ready)
`ifdef FB_WRITE_DROP_CNT_EN
        , .o_drop_cnt(s_drop_cnt)
`endif
    );

    typedef struct packed {
        logic        en;
        logic [16:0] addr;
        logic [11:0] data;
    } exp_t;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic        vld;
        logic [11:0] d;
        logic        en;
        logic [16:0] addr;
        logic [11:0] wd;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   wr_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_fs();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    // Drive one pixel cycle on the main DUT; the expected output is queued and popped one edge later.
    task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic vld,
                         input logic [11:0] d, input logic exp_en, input logic [16:0] exp_addr,
                         input logic [11:0] exp_data, input string name);
        exp_t e;
        exp_t got;
        i_h_addr     = h;
        i_v_addr     = v;
        i_valid      = vld;
        i_pixel_data = d;
        e.en   = exp_en;
        e.addr = exp_addr;
        e.data = exp_data;
        sb_q.push_back(e);
        tick();
        i_valid = 1'b0;
        if (o_wr_en) wr_count++;
        got = sb_q.pop_front();
        check(name, 32'({o_wr_en, o_wr_addr, o_wr_data}), 32'(got));
    endtask

    task automatic s_drive(input logic [10:0] h, input logic [9:0] v, input logic [11:0] d,
                           input logic exp_en, input logic [2:0] exp_addr, input string name);
        s_h_addr     = h;
        s_v_addr     = v;
        s_valid      = 1'b1;
        s_pixel_data = d;
        tick();
        s_valid = 1'b0;
        check({name, "_en"}, 32'(s_wr_en), 32'(exp_en));
        if (exp_en) begin
            check({name, "_addr"}, 32'(s_wr_addr), 32'(exp_addr));
            check({name, "_data"}, 32'(s_wr_data), 32'(d));
        end
    endtask

    logic [11:0] d;
    logic [11:0] last_d;

    initial begin
        vecs[0] = '{h: 11'd6,   v: 10'd4,   vld: 1'b1, d: 12'hABC, en: 1'b1, addr: 17'd643,   wd: 12'hABC};
        vecs[1] = '{h: 11'd7,   v: 10'd4,   vld: 1'b1, d: 12'h111, en: 1'b0, addr: 17'd643,   wd: 12'hABC};
        vecs[2] = '{h: 11'd4,   v: 10'd5,   vld: 1'b1, d: 12'h222, en: 1'b0, addr: 17'd643,   wd: 12'hABC};
        vecs[3] = '{h: 11'd640, v: 10'd0,   vld: 1'b1, d: 12'h333, en: 1'b0, addr: 17'd643,   wd: 12'hABC};
        vecs[4] = '{h: 11'd0,   v: 10'd480, vld: 1'b1, d: 12'h444, en: 1'b0, addr: 17'd643,   wd: 12'hABC};
        vecs[5] = '{h: 11'd638, v: 10'd478, vld: 1'b1, d: 12'h5A5, en: 1'b1, addr: 17'd76799, wd: 12'h5A5};
        vecs[6] = '{h: 11'd0,   v: 10'd0,   vld: 1'b1, d: 12'h0F0, en: 1'b1, addr: 17'd0,     wd: 12'h0F0};
        vecs[7] = '{h: 11'd2,   v: 10'd2,   vld: 1'b0, d: 12'h777, en: 1'b0, addr: 17'd0,     wd: 12'h0F0};

        // Reset both DUTs
        i_rst = 1'b1;
        s_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        s_rst = 1'b0;
        check("rst_wr_state", 32'({o_wr_en, o_wr_addr, o_wr_data}), 32'(0));
        check("rst_banks", 32'({o_wr_bank, o_rd_bank}), 32'(2'b01));
        check("rst_swap_ready", 32'({o_swap, o_frame_ready}), 32'(0));
`ifdef FB_WRITE_DROP_CNT_EN
        check("rst_drop", 32'(o_drop_cnt), 32'(0));
`endif

        // IDLE ignores pixels and reader-done
        drive(11'd0, 10'd0, 1'b1, 12'hFFF, 1'b0, 17'd0, 12'h000, "idle_ignore_px");
        i_rd_frame_done = 1'b1;
        tick();
        i_rd_frame_done = 1'b0;
        check("idle_rd_done_no_swap", 32'({o_swap, o_wr_bank}), 32'(0));

        pulse_fs();
        i_rd_frame_done = 1'b1;
        tick();
        i_rd_frame_done = 1'b0;
        check("write_rd_done_no_swap", 32'({o_swap, o_wr_bank}), 32'(0));

        foreach (vecs[i])
            drive(vecs[i].h, vecs[i].v, vecs[i].vld, vecs[i].d, vecs[i].en, vecs[i].addr,
                  vecs[i].wd, $sformatf("vec%0d", i));
        check("vec_bank", 32'(o_wr_bank), 32'(0));

        // Bring the partial frame to 100 writes, then abandon it
        for (int k = 0; k < 97; k++)
            drive(11'(2 * k), 10'd2, 1'b1, 12'(k), 1'b1, 17'(320 + k), 12'(k), "partial_px");
        pulse_fs();
        check("restart_no_write", 32'(o_wr_en), 32'(0));
`ifdef FB_WRITE_DROP_CNT_EN
        check("drop_after_abandon", 32'(o_drop_cnt), 32'(1));
`endif

        // Full frame: every even pixel of 640x480, one per cycle
        wr_count = 0;
        last_d   = '0;
        for (int v = 0; v < 480; v += 2) begin
            for (int h = 0; h < 640; h += 2) begin
                d = 12'(h * 7 + v * 13);
                if (v == 478 && h == 638)
                    check("ready_before_last", 32'(o_frame_ready), 32'(0));
                drive(11'(h), 10'(v), 1'b1, d, 1'b1, 17'((v / 2) * 320 + h / 2), d, "frame_px");
                last_d = d;
            end
        end
        check("frame_write_count", 32'(wr_count), 32'(76800));
        check("frame_last_addr", 32'(o_wr_addr), 32'(76799));
        check("frame_ready", 32'(o_frame_ready), 32'(1));
        check("frame_bank", 32'(o_wr_bank), 32'(0));

        // WAIT_SWAP: no writes, lone frame_start dropped
        drive(11'd0, 10'd0, 1'b1, 12'h321, 1'b0, 17'd76799, last_d, "wait_no_write");
        pulse_fs();
        check("wait_fs_banks", 32'({o_wr_bank, o_rd_bank, o_swap}), 32'(3'b010));
        check("wait_fs_ready", 32'(o_frame_ready), 32'(1));
`ifdef FB_WRITE_DROP_CNT_EN
        check("drop_after_wait_fs", 32'(o_drop_cnt), 32'(2));
`endif

        // Reader done alone: swap and go IDLE
        i_rd_frame_done = 1'b1;
        tick();
        i_rd_frame_done = 1'b0;
        check("swap_pulse", 32'(o_swap), 32'(1));
        check("swap_banks", 32'({o_wr_bank, o_rd_bank}), 32'(2'b10));
        check("swap_ready_clr", 32'(o_frame_ready), 32'(0));
        tick();
        check("swap_one_cycle", 32'(o_swap), 32'(0));
        drive(11'd0, 10'd0, 1'b1, 12'h456, 1'b0, 17'd76799, last_d, "post_swap_idle");
        pulse_fs();
        drive(11'd2, 10'd0, 1'b1, 12'h9E1, 1'b1, 17'd1, 12'h9E1, "bank1_write");
        check("bank1_banks", 32'({o_wr_bank, o_rd_bank}), 32'(2'b10));

        // Reset mid-frame cancels the in-flight write
        i_rst = 1'b1;
        drive(11'd4, 10'd0, 1'b1, 12'hCCC, 1'b0, 17'd0, 12'h000, "rst_mid_frame");
        i_rst = 1'b0;
        check("rst_mid_banks", 32'({o_wr_bank, o_rd_bank, o_frame_ready}), 32'(3'b010));
`ifdef FB_WRITE_DROP_CNT_EN
        check("rst_mid_drop", 32'(o_drop_cnt), 32'(0));
`endif
        drive(11'd0, 10'd0, 1'b1, 12'h1AB, 1'b0, 17'd0, 12'h000, "rst_back_idle");

        // Small DUT: boundaries, full 4x2 frame, then simultaneous swap+start
        s_frame_start = 1'b1;
        tick();
        s_frame_start = 1'b0;
        s_drive(11'd8, 10'd0, 12'h101, 1'b0, 3'd0, "s_h_edge");
        s_drive(11'd0, 10'd4, 12'h102, 1'b0, 3'd0, "s_v_edge");
        for (int v = 0; v < 4; v += 2)
            for (int h = 0; h < 8; h += 2)
                s_drive(11'(h), 10'(v), 12'(16 * v + h), 1'b1, 3'((v / 2) * 4 + h / 2), "s_px");
        check("s_ready", 32'(s_frame_ready), 32'(1));
        s_drive(11'd0, 10'd0, 12'h103, 1'b0, 3'd0, "s_wait_no_write");
        s_frame_start   = 1'b1;
        s_rd_frame_done = 1'b1;
        tick();
        s_frame_start   = 1'b0;
        s_rd_frame_done = 1'b0;
        check("s_sim_swap", 32'({s_swap, s_wr_bank, s_rd_bank, s_frame_ready}), 32'(4'b1100));
`ifdef FB_WRITE_DROP_CNT_EN
        check("s_sim_no_drop", 32'(s_drop_cnt), 32'(0));
`endif
        s_drive(11'd0, 10'd0, 12'hE0E, 1'b1, 3'd0, "s_new_bank_px");
        check("s_new_bank", 32'({s_wr_bank, s_swap}), 32'(2'b10));

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
